// File: rtl/sokoban_core.sv
// Sokoban game engine: loadable wall/target/box map, handshaked moves with push
// resolution against walls, boxes and map edges, saturating counters and win detection.
module sokoban_core #(
    parameter int MAP_W = 16,
    parameter int MAP_H = 12,
    parameter int XW    = 4,
    parameter int YW    = 4,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load_we,
    input  logic [XW-1:0]    load_x,
    input  logic [YW-1:0]    load_y,
    input  logic [2:0]       load_tile,
    input  logic             start,
    input  logic             move_valid,
    input  logic [1:0]       move_dir,
    output logic             move_ready,
    output logic             move_done,
    output logic             move_blocked,
    input  logic [XW-1:0]    q_x,
    input  logic [YW-1:0]    q_y,
    output logic [2:0]       q_tile,
    output logic [XW-1:0]    player_x,
    output logic [YW-1:0]    player_y,
    output logic [CNT_W-1:0] moves,
    output logic [CNT_W-1:0] pushes,
    output logic [XW+YW-1:0] boxes_on_target,
    output logic [1:0]       game_state
);
    // state  | meaning
    // S_IDLE | level loading, tile writes accepted
    // S_PLAY | waiting for a move request
    // S_MOVE | resolving the latched move
    // S_WIN  | all boxes on targets, map frozen until clear/reset

    localparam int NC = MAP_W * MAP_H;
    localparam int IW = $clog2(NC);
    localparam int BW = XW + YW;
    localparam logic [XW:0] W_LIM = (XW+1)'(MAP_W);
    localparam logic [YW:0] H_LIM = (YW+1)'(MAP_H);
    localparam logic [XW:0] DX1   = (XW+1)'(1);
    localparam logic [XW:0] DX2   = (XW+1)'(2);
    localparam logic [YW:0] DY1   = (YW+1)'(1);
    localparam logic [YW:0] DY2   = (YW+1)'(2);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_MOVE = 2'b10,
        S_WIN  = 2'b11
    } state_t;

    state_t          state;
    logic [1:0]      dir;
    logic [NC-1:0]   wall, target, box;
    logic [NC-1:0]   wall_n, target_n, box_n;
    logic [XW-1:0]   px_n;
    logic [YW-1:0]   py_n;
    logic [XW:0]     nx, bx;
    logic [YW:0]     ny, by;
    logic            n_in, b_in, b_free, mv_ok, mv_push;
    logic            l_in, q_in;
    logic [IW-1:0]   n_idx, b_idx, l_idx, q_idx;
    logic [BW-1:0]   bot_n, nbox_n;
    logic            win_n;
    logic [2:0]      q_next;

    function automatic logic [IW-1:0] cidx(input logic [XW:0] x, input logic [YW:0] y);
        return IW'(32'(y) * MAP_W + 32'(x));
    endfunction

    function automatic logic [BW-1:0] popcnt(input logic [NC-1:0] v);
        logic [BW-1:0] c;
        c = '0;
        for (int i = 0; i < NC; i++) c = c + BW'(v[i]);
        return c;
    endfunction

    // One extra coordinate bit lets a step off the low edge wrap to a value above the limit.
    always_comb begin
        nx = {1'b0, player_x};
        ny = {1'b0, player_y};
        bx = nx;
        by = ny;
        case (dir)
            2'd0:    begin ny = ny - DY1; by = by - DY2; end
            2'd1:    begin ny = ny + DY1; by = by + DY2; end
            2'd2:    begin nx = nx - DX1; bx = bx - DX2; end
            default: begin nx = nx + DX1; bx = bx + DX2; end
        endcase
    end

    assign n_in    = (nx < W_LIM) && (ny < H_LIM);
    assign b_in    = (bx < W_LIM) && (by < H_LIM);
    assign n_idx   = cidx(nx, ny);
    assign b_idx   = cidx(bx, by);
    assign b_free  = b_in && !wall[b_idx] && !box[b_idx];
    assign mv_ok   = n_in && !wall[n_idx] && (!box[n_idx] || b_free);
    assign mv_push = n_in && !wall[n_idx] && box[n_idx] && b_free;

    assign l_in  = ({1'b0, load_x} < W_LIM) && ({1'b0, load_y} < H_LIM);
    assign l_idx = cidx({1'b0, load_x}, {1'b0, load_y});
    assign q_in  = ({1'b0, q_x} < W_LIM) && ({1'b0, q_y} < H_LIM);
    assign q_idx = cidx({1'b0, q_x}, {1'b0, q_y});

    always_comb begin
        wall_n   = wall;
        target_n = target;
        box_n    = box;
        px_n     = player_x;
        py_n     = player_y;
        if (clear) begin
            wall_n   = '0;
            target_n = '0;
            box_n    = '0;
            px_n     = '0;
            py_n     = '0;
        end else if (state == S_IDLE && load_we && l_in) begin
            wall_n[l_idx]   = 1'b0;
            target_n[l_idx] = 1'b0;
            box_n[l_idx]    = 1'b0;
            case (load_tile)
                3'b001: wall_n[l_idx] = 1'b1;
                3'b010: box_n[l_idx] = 1'b1;
                3'b011: target_n[l_idx] = 1'b1;
                3'b100: begin px_n = load_x; py_n = load_y; end
                3'b101: begin box_n[l_idx] = 1'b1; target_n[l_idx] = 1'b1; end
                default: ;
            endcase
        end else if (state == S_MOVE && mv_ok) begin
            if (mv_push) begin
                box_n[n_idx] = 1'b0;
                box_n[b_idx] = 1'b1;
            end
            px_n = nx[XW-1:0];
            py_n = ny[YW-1:0];
        end
    end

    // Win is judged on the post-move map so it lands in the same edge as the move.
    assign bot_n  = popcnt(box_n & target_n);
    assign nbox_n = popcnt(box_n);
    assign win_n  = (nbox_n != '0) && (bot_n == nbox_n);

    always_comb begin
        q_next = 3'b000;
        if (!q_in)                                   q_next = 3'b001;
        else if (q_x == player_x && q_y == player_y) q_next = 3'b100;
        else if (box[q_idx] && target[q_idx])        q_next = 3'b101;
        else if (box[q_idx])                         q_next = 3'b010;
        else if (wall[q_idx])                        q_next = 3'b001;
        else if (target[q_idx])                      q_next = 3'b011;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            dir             <= 2'd0;
            wall            <= '0;
            target          <= '0;
            box             <= '0;
            player_x        <= '0;
            player_y        <= '0;
            moves           <= '0;
            pushes          <= '0;
            boxes_on_target <= '0;
            move_done       <= 1'b0;
            move_blocked    <= 1'b0;
            q_tile          <= 3'b000;
        end else begin
            wall            <= wall_n;
            target          <= target_n;
            box             <= box_n;
            player_x        <= px_n;
            player_y        <= py_n;
            boxes_on_target <= bot_n;
            q_tile          <= q_next;
            move_done       <= 1'b0;
            move_blocked    <= 1'b0;
            if (clear) begin
                state  <= S_IDLE;
                moves  <= '0;
                pushes <= '0;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        state  <= S_PLAY;
                        moves  <= '0;
                        pushes <= '0;
                    end
                    S_PLAY: if (move_valid) begin
                        dir   <= move_dir;
                        state <= S_MOVE;
                    end
                    S_MOVE: begin
                        if (mv_ok) begin
                            move_done <= 1'b1;
                            if (moves != '1) moves <= moves + CNT_W'(1);
                            if (mv_push && pushes != '1) pushes <= pushes + CNT_W'(1);
                        end else begin
                            move_blocked <= 1'b1;
                        end
                        state <= win_n ? S_WIN : S_PLAY;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign move_ready = (state == S_PLAY);
    assign game_state = state;

endmodule

// File: tb/tb_sokoban_core.sv
// Bench for sokoban_core: directed level scenarios plus random levels and moves,
// checked against a grid-based reference model of the game rules.
module tb_sokoban_core;
    localparam int MW = 16;
    localparam int MH = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       load_we = 1'b0;
    logic [3:0] load_x = '0;
    logic [3:0] load_y = '0;
    logic [2:0] load_tile = '0;
    logic       start = 1'b0;
    logic       move_valid = 1'b0;
    logic [1:0] move_dir = '0;
    logic [3:0] q_x = '0;
    logic [3:0] q_y = '0;

    logic       move_ready, move_done, move_blocked;
    logic [2:0] q_tile;
    logic [3:0] player_x, player_y;
    logic [9:0] moves, pushes;
    logic [7:0] boxes_on_target;
    logic [1:0] game_state;

    logic       d2_ready, d2_done, d2_blocked;
    logic [2:0] d2_q_tile;
    logic [3:0] d2_px, d2_py;
    logic [1:0] d2_moves, d2_pushes;
    logic [7:0] d2_bot;
    logic [1:0] d2_state;

    sokoban_core #(.MAP_W(16), .MAP_H(12), .XW(4), .YW(4), .CNT_W(10)) dut (
        .clk(clk), .reset(reset), .clear(clear), .load_we(load_we),
        .load_x(load_x), .load_y(load_y), .load_tile(load_tile), .start(start),
        .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
        .move_done(move_done), .move_blocked(move_blocked), .q_x(q_x), .q_y(q_y),
        .q_tile(q_tile), .player_x(player_x), .player_y(player_y), .moves(moves),
        .pushes(pushes), .boxes_on_target(boxes_on_target), .game_state(game_state)
    );

    sokoban_core #(.MAP_W(16), .MAP_H(12), .XW(4), .YW(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .clear(clear), .load_we(load_we),
        .load_x(load_x), .load_y(load_y), .load_tile(load_tile), .start(start),
        .move_valid(move_valid), .move_dir(move_dir), .move_ready(d2_ready),
        .move_done(d2_done), .move_blocked(d2_blocked), .q_x(q_x), .q_y(q_y),
        .q_tile(d2_q_tile), .player_x(d2_px), .player_y(d2_py), .moves(d2_moves),
        .pushes(d2_pushes), .boxes_on_target(d2_bot), .game_state(d2_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: plain grid of cells, player coordinates, raw counters
    bit mw [MW][MH];
    bit mb [MW][MH];
    bit mt [MW][MH];
    int mpx, mpy, mst, mmoves, mpushes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit inb(input int x, input int y);
        return x >= 0 && x < MW && y >= 0 && y < MH;
    endfunction

    function automatic int m_bot();
        int c = 0;
        for (int x = 0; x < MW; x++) for (int y = 0; y < MH; y++) if (mb[x][y] && mt[x][y]) c++;
        return c;
    endfunction

    function automatic int m_nbox();
        int c = 0;
        for (int x = 0; x < MW; x++) for (int y = 0; y < MH; y++) if (mb[x][y]) c++;
        return c;
    endfunction

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [2:0] exp_tile(input int x, input int y);
        if (!inb(x, y)) return 3'b001;
        if (x == mpx && y == mpy) return 3'b100;
        if (mb[x][y] && mt[x][y]) return 3'b101;
        if (mb[x][y]) return 3'b010;
        if (mw[x][y]) return 3'b001;
        if (mt[x][y]) return 3'b011;
        return 3'b000;
    endfunction

    task automatic m_reset();
        for (int x = 0; x < MW; x++) for (int y = 0; y < MH; y++) begin
            mw[x][y] = 1'b0; mb[x][y] = 1'b0; mt[x][y] = 1'b0;
        end
        mpx = 0; mpy = 0; mst = 0; mmoves = 0; mpushes = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int x, input int y, input int code);
        load_we = 1'b1; load_x = x[3:0]; load_y = y[3:0]; load_tile = code[2:0];
        cyc();
        load_we = 1'b0;
        if (mst == 0 && inb(x, y)) begin
            mw[x][y] = 1'b0; mb[x][y] = 1'b0; mt[x][y] = 1'b0;
            case (code)
                1: mw[x][y] = 1'b1;
                2: mb[x][y] = 1'b1;
                3: mt[x][y] = 1'b1;
                4: begin mpx = x; mpy = y; end
                5: begin mb[x][y] = 1'b1; mt[x][y] = 1'b1; end
                default: ;
            endcase
        end
        chk("load_bot", boxes_on_target, m_bot());
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
        if (mst == 0) begin mst = 1; mmoves = 0; mpushes = 0; end
        chk("start_state", game_state, mst);
        chk("start_moves", moves, sat(mmoves, 1023));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        m_reset();
        chk("clr_state", game_state, 0);
        chk("clr_moves", moves, 0);
        chk("clr_pushes", pushes, 0);
        chk("clr_bot", boxes_on_target, 0);
        chk("clr_px", player_x, 0);
    endtask

    task automatic query(input int x, input int y, input string tag);
        q_x = x[3:0]; q_y = y[3:0];
        cyc();
        chk(tag, q_tile, exp_tile(x, y));
        chk({tag, "_d2"}, d2_q_tile, exp_tile(x, y));
    endtask

    task automatic model_move(input int d, output bit ok);
        int dx = 0, dy = 0, nx, ny, bx, by;
        case (d)
            0: dy = -1;
            1: dy = 1;
            2: dx = -1;
            default: dx = 1;
        endcase
        nx = mpx + dx; ny = mpy + dy; bx = nx + dx; by = ny + dy;
        ok = 1'b0;
        if (inb(nx, ny) && !mw[nx][ny]) begin
            if (!mb[nx][ny]) ok = 1'b1;
            else if (inb(bx, by) && !mw[bx][by] && !mb[bx][by]) begin
                ok = 1'b1;
                mb[nx][ny] = 1'b0;
                mb[bx][by] = 1'b1;
                mpushes++;
            end
        end
        if (ok) begin mpx = nx; mpy = ny; mmoves++; end
        mst = (m_nbox() > 0 && m_bot() == m_nbox()) ? 3 : 1;
    endtask

    task automatic do_move(input int d);
        bit ok;
        chk("mv_ready", move_ready, mst == 1);
        move_valid = 1'b1; move_dir = d[1:0];
        cyc();
        move_valid = 1'b0;
        if (mst == 1) begin
            chk("mv_in_move", game_state, 2);
            chk("mv_ready_low", move_ready, 0);
            cyc();
            model_move(d, ok);
            chk("mv_done", move_done, ok);
            chk("mv_blocked", move_blocked, !ok);
            chk("mv_px", player_x, mpx);
            chk("mv_py", player_y, mpy);
            chk("mv_moves", moves, sat(mmoves, 1023));
            chk("mv_pushes", pushes, sat(mpushes, 1023));
            chk("mv_bot", boxes_on_target, m_bot());
            chk("mv_state", game_state, mst);
            chk("mv_ready_back", move_ready, mst == 1);
            chk("d2_done", d2_done, ok);
            chk("d2_blocked", d2_blocked, !ok);
            chk("d2_px", d2_px, mpx);
            chk("d2_py", d2_py, mpy);
            chk("d2_moves", d2_moves, sat(mmoves, 3));
            chk("d2_pushes", d2_pushes, sat(mpushes, 3));
            chk("d2_bot", d2_bot, m_bot());
            chk("d2_state", d2_state, mst);
            chk("d2_ready", d2_ready, mst == 1);
        end else begin
            chk("win_hold_state", game_state, 3);
            chk("win_no_done", move_done, 0);
            cyc();
            chk("win_no_done2", move_done, 0);
            chk("win_px", player_x, mpx);
            chk("win_moves", moves, sat(mmoves, 1023));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int codes[10] = '{0, 1, 1, 2, 2, 3, 3, 5, 6, 7};
        m_reset();
        cyc(); cyc();
        chk("rst_state", game_state, 0);
        chk("rst_ready", move_ready, 0);
        chk("rst_done", move_done, 0);
        chk("rst_blocked", move_blocked, 0);
        chk("rst_qtile", q_tile, 0);
        chk("rst_px", player_x, 0);
        chk("rst_py", player_y, 0);
        chk("rst_moves", moves, 0);
        chk("rst_pushes", pushes, 0);
        chk("rst_bot", boxes_on_target, 0);
        reset = 1'b0;
        cyc();

        // level 1: bordered room, walk right
        for (int x = 0; x < MW; x++) begin load(x, 0, 1); load(x, MH - 1, 1); end
        for (int y = 1; y < MH - 1; y++) begin load(0, y, 1); load(MW - 1, y, 1); end
        load(6, 3, 4); load(4, 6, 2); load(10, 5, 3);
        load(3, 12, 1);
        do_start();
        chk("l1_ready", move_ready, 1);
        query(6, 3, "q_player");
        query(4, 6, "q_box");
        query(10, 5, "q_target");
        query(0, 0, "q_wall");
        query(5, 12, "q_oob_y");
        query(3, 3, "q_empty");
        load(8, 8, 1);
        query(8, 8, "q_load_in_play");
        do_move(3);
        chk("l1_px_const", player_x, 7);
        chk("l1_moves_const", moves, 1);

        // level 2: push then blocked by wall behind box
        do_clear();
        load(5, 5, 4); load(6, 5, 2); load(8, 5, 1);
        do_start();
        do_move(3);
        chk("l2_push_const", pushes, 1);
        query(7, 5, "q_pushed_box");
        do_move(3);
        chk("l2_blk_const", move_blocked, 1);

        // level 3: box against box
        do_clear();
        load(5, 5, 4); load(6, 5, 2); load(7, 5, 2);
        do_start();
        do_move(3);
        chk("l3_boxbox_blk", move_blocked, 1);

        // level 4: map edge
        do_clear();
        do_start();
        do_move(0);
        chk("l4_edge_blk", move_blocked, 1);
        do_move(2);
        do_move(1);

        // level 5: two boxes, two targets, win
        do_clear();
        load(2, 2, 4); load(3, 2, 2); load(4, 2, 3); load(2, 4, 2); load(2, 6, 3);
        load(9, 9, 5); load(9, 9, 0);
        do_start();
        do_move(3);
        chk("l5_bot1", boxes_on_target, 1);
        do_move(2); do_move(1); do_move(1); do_move(1);
        chk("l5_win", game_state, 2'b11);
        chk("l5_d2_sat", d2_moves, 3);
        do_move(0);
        query(4, 2, "q_box_on_tgt");
        query(2, 5, "q_win_player");
        do_clear();
        query(4, 2, "q_after_clear");
        query(0, 0, "q_after_clear_p");

        // reset mid-move
        load(3, 3, 4);
        do_start();
        do_move(3);
        move_valid = 1'b1; move_dir = 2'd3;
        cyc();
        move_valid = 1'b0;
        chk("ar_in_move", game_state, 2);
        #2 reset = 1'b1;
        #1;
        chk("ar_state", game_state, 0);
        chk("ar_moves", moves, 0);
        chk("ar_px", player_x, 0);
        chk("ar_done", move_done, 0);
        chk("ar_ready", move_ready, 0);
        m_reset();
        cyc();
        reset = 1'b0;
        cyc();
        chk("ar_after_state", game_state, 0);

        // random levels and moves
        for (int r = 0; r < 4; r++) begin
            do_clear();
            for (int i = 0; i < 60; i++)
                load($urandom_range(0, 15), $urandom_range(0, 15), codes[$urandom_range(0, 9)]);
            load($urandom_range(0, 15), $urandom_range(0, 11), 4);
            do_start();
            for (int i = 0; i < 70; i++) begin
                do_move($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0)
                    query($urandom_range(0, 15), $urandom_range(0, 15), "q_rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sokoban_core.md
# sokoban_core

Parametrised Sokoban game engine: holds a loadable level (walls, targets, N boxes, player), accepts handshaked move commands, resolves walking/pushing against walls, boxes and map edges, counts moves and pushes, and detects the win. Sits between the key/direction decoder and the VGA tile renderer. The renderer reads tiles through a registered query port. Successor to the fixed single-box, single-target engine: map size is generic, there are multiple boxes/targets, and the engine adds a handshake, counters and a status port.

## Interface
- MAP_W, 16, map width in tiles
- MAP_H, 12, map height in tiles
- XW, 4, x coordinate width (≥ clog2(MAP_W))
- YW, 4, y coordinate width (≥ clog2(MAP_H))
- CNT_W, 10, move/push counter width
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- clear  in  1  synchronous level wipe, any state -> IDLE
- load_we  in  1  tile write strobe (IDLE only)
- load_x / load_y  in  XW / YW  tile write coordinate
- load_tile  in  3  000 empty, 001 wall, 010 box, 011 target, 100 player, 101 box-on-target
- start  in  1  IDLE -> PLAY
- move_valid  in  1  move request
- move_dir  in  2  0 up, 1 down, 2 left, 3 right
- move_ready  out  1  high only in PLAY
- move_done  out  1  1-cycle pulse, move accepted and executed
- move_blocked  out  1  1-cycle pulse, move rejected
- q_x / q_y  in  XW / YW  renderer query coordinate
- q_tile  out  3  tile at (q_x,q_y), registered, same encoding
- player_x / player_y  out  XW / YW  player position
- moves / pushes  out  CNT_W  saturating counters
- boxes_on_target  out  XW+YW  count of boxes covering targets
- game_state  out  2  00 IDLE, 01 PLAY, 10 MOVE, 11 WIN

## Operation
- Storage: three MAP_W*MAP_H bit vectors (wall, target, box) plus the player register.
- IDLE: load_we writes one tile per cycle. Writes with an out-of-range coordinate are ignored. A write first clears that cell's wall, box and target bits, then sets the bits the code implies (101 sets box and target). Code 100 moves the player and leaves the cell bits empty. Codes 110/111 act as empty. load_we in other states is ignored.
- start in IDLE -> PLAY; counters are cleared. start elsewhere is ignored.
- PLAY: move_valid && move_ready accepts move_dir and enters MOVE (1 cycle). In MOVE, with N the neighbour in move_dir and B the cell beyond:
  - N out of bounds or wall -> blocked.
  - N holds a box: if B is in bounds, not a wall and not a box, the box moves N->B, the player moves to N, moves++ and pushes++. Otherwise blocked.
  - Otherwise the player moves to N and moves++.
- Exit from MOVE: if the total box count is >0 and boxes_on_target equals the box count, go to WIN; else return to PLAY.
- WIN: moves are ignored and the map is frozen. Exit only via clear or reset.
- clear, from any state: all vectors zero, player (0,0), counters 0, IDLE. clear has priority over start and moves in the same cycle.
- Counters saturate at 2^CNT_W-1.
- q_tile priority: player > box-on-target (101) > box > wall > target > empty. An out-of-range query returns 001.

## Timing
- Reset values: game_state 00, move_ready 0, move_done 0, move_blocked 0, q_tile 000, player (0,0), moves 0, pushes 0, boxes_on_target 0, all map bits 0.
- Move latency: accept at edge T (state -> MOVE). At edge T+1, positions, counters, move_done/move_blocked (high for cycle T+1..T+2) and the next state all update together. move_ready returns at T+1 if the state is PLAY. Maximum throughput is 1 move per 2 cycles.
- boxes_on_target is registered and updates with the map. The win check in MOVE uses the post-move value, computed combinationally.
- q_tile latency is 1 cycle and reflects the map state at the sampling edge.
- Reset asserted mid-MOVE: the move is aborted and all outputs return to reset values immediately (asynchronously).

## Test plan
- Load 16x12 border walls, player (6,3), box (4,6), target (10,5); start; move right -> player (7,3), moves=1, pushes=0, move_done pulse, state back to 01.
- Player (5,5), box (6,5), empty (7,5); move right -> box (7,5), player (6,5), pushes=1. Repeat with a wall at (8,5) -> move_blocked, positions and counters unchanged.
- Box-box push: boxes at (6,5) and (7,5), player (5,5), move right -> blocked. Player at (0,0) without walls, move up -> blocked (edge).
- Two boxes / two targets; push the first onto its target -> boxes_on_target=1, state 01. Push the second -> state 11 one cycle after accept; further move_valid -> no move_done, move_ready=0.
- Query port: q_(6,3) -> 100, box on target -> 101, (16,0) -> 001, each one cycle later. Load attempts in PLAY -> map unchanged.
- Assert reset during MOVE -> immediately state 00, counters 0. clear in WIN -> IDLE with an empty map. Preload CNT_W=2 and make 5 moves -> moves=3.
